// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: streams packed filter weights into the weight store, confirms FULL,
// and holds each filter for the MAC array until released, for CFG_NUM_FILTERS filters per job.
module weight_load_ctrl #(
    parameter int INPUT_WIDTH   = 32,
    parameter int BUFFER_WIDTH  = 40,
    parameter int NUM_FILTERS_W = 8,
    parameter int FULL_TIMEOUT  = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CFG_START,
    input  logic [3:0]               CFG_R,
    input  logic [3:0]               CFG_S,
    input  logic [NUM_FILTERS_W-1:0] CFG_NUM_FILTERS,
    input  logic [INPUT_WIDTH-1:0]   S_DATA,
    input  logic                     S_VALID,
    output logic                     S_READY,
    output logic                     WS_WR_EN,
    output logic                     WS_WR_VALID,
    output logic [INPUT_WIDTH-1:0]   WS_WR_DATA,
    output logic [3:0]               WS_PARAM_R,
    output logic [3:0]               WS_PARAM_S,
    input  logic                     WS_FULL,
    output logic                     W_READY,
    input  logic                     W_RELEASE,
    output logic [NUM_FILTERS_W-1:0] FILTER_IDX,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR
);
    localparam int TW = $clog2(FULL_TIMEOUT + 1);
    localparam logic [3:0] MAX_RS = 4'(BUFFER_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_FULL, HOLD} state_t;

    state_t                   state_q;
    logic [3:0]               r_q, s_q;
    logic [NUM_FILTERS_W-1:0] nf_q, idx_q;
    logic [2:0]               wc_q;
    logic [TW-1:0]            timer_q;
    logic                     err_q, done_q;
    logic [11:0]              bits_w;
    logic [2:0]               exp_w;
    logic                     cfg_ok, beat, early_full;

    // Rows narrower than a stream word take one word each; wider rows pack across words.
    assign bits_w     = 12'(r_q) * 12'(s_q) * 12'd8;
    assign exp_w      = (12'(s_q) * 12'd8 <= 12'(INPUT_WIDTH)) ? 3'(r_q)
                      : 3'((bits_w + 12'(INPUT_WIDTH - 1)) / 12'(INPUT_WIDTH));
    assign cfg_ok     = (CFG_R != 4'd0) && (CFG_R <= MAX_RS) && (CFG_S != 4'd0) && (CFG_S <= MAX_RS)
                      && (CFG_NUM_FILTERS != '0);
    assign beat       = S_VALID && (state_q == LOAD);
    // FULL before the second beat is a leftover from the previous filter and is ignored.
    assign early_full = WS_FULL && (wc_q >= 3'd2) && (wc_q < exp_w);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            r_q     <= '0;
            s_q     <= '0;
            nf_q    <= '0;
            idx_q   <= '0;
            wc_q    <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (CFG_START && cfg_ok) begin
                        r_q     <= CFG_R;
                        s_q     <= CFG_S;
                        nf_q    <= CFG_NUM_FILTERS;
                        idx_q   <= '0;
                        wc_q    <= '0;
                        err_q   <= 1'b0;
                        state_q <= LOAD;
                    end else if (CFG_START) begin
                        err_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (early_full) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (beat) begin
                        wc_q <= wc_q + 3'd1;
                        if (wc_q == exp_w - 3'd1) begin
                            timer_q <= '0;
                            state_q <= WAIT_FULL;
                        end
                    end
                end
                WAIT_FULL: begin
                    if (WS_FULL) begin
                        state_q <= HOLD;
                    end else if (timer_q == TW'(FULL_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                HOLD: begin
                    if (W_RELEASE && (idx_q == nf_q - NUM_FILTERS_W'(1))) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (W_RELEASE) begin
                        idx_q   <= idx_q + NUM_FILTERS_W'(1);
                        wc_q    <= '0;
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign S_READY     = (state_q == LOAD);
    assign WS_WR_EN    = (state_q == LOAD);
    assign WS_WR_VALID = S_VALID & S_READY;
    assign WS_WR_DATA  = S_DATA;
    assign WS_PARAM_R  = r_q;
    assign WS_PARAM_S  = s_q;
    assign W_READY     = (state_q == HOLD);
    assign FILTER_IDX  = idx_q;
    assign BUSY        = (state_q != IDLE);
    assign DONE        = done_q;
    assign ERR         = err_q;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed jobs with a write-data scoreboard drained by a monitor on the falling edge.
module tb_weight_load_ctrl;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CFG_START = 1'b0;
    logic [3:0]  CFG_R = '0, CFG_S = '0;
    logic [7:0]  CFG_NUM_FILTERS = '0;
    logic [31:0] S_DATA = '0;
    logic        S_VALID = 1'b0;
    logic        S_READY, WS_WR_EN, WS_WR_VALID;
    logic [31:0] WS_WR_DATA;
    logic [3:0]  WS_PARAM_R, WS_PARAM_S;
    logic        WS_FULL = 1'b0;
    logic        W_READY;
    logic        W_RELEASE = 1'b0;
    logic [7:0]  FILTER_IDX;
    logic        BUSY, DONE, ERR;

    int total = 0, bad = 0, beat_cnt = 0, cyc = 0;
    logic [31:0] exp_q[$];

    weight_load_ctrl dut (
        .CLK(CLK), .RESET(RESET), .CFG_START(CFG_START), .CFG_R(CFG_R), .CFG_S(CFG_S),
        .CFG_NUM_FILTERS(CFG_NUM_FILTERS), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .WS_WR_EN(WS_WR_EN), .WS_WR_VALID(WS_WR_VALID), .WS_WR_DATA(WS_WR_DATA),
        .WS_PARAM_R(WS_PARAM_R), .WS_PARAM_S(WS_PARAM_S), .WS_FULL(WS_FULL), .W_READY(W_READY),
        .W_RELEASE(W_RELEASE), .FILTER_IDX(FILTER_IDX), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    always @(negedge CLK) begin
        if (WS_WR_VALID) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got=%0h want=none", WS_WR_DATA);
            end else begin
                check("wr_data", WS_WR_DATA, exp_q.pop_front());
            end
            check("wr_en", WS_WR_EN, 1);
        end
        if (DONE) check("done_not_busy", BUSY, 0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [3:0] r, input logic [3:0] s, input logic [7:0] nf);
        CFG_R = r;
        CFG_S = s;
        CFG_NUM_FILTERS = nf;
        CFG_START = 1'b1;
        tick();
        CFG_START = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input int gap);
        int w = 0;
        S_VALID = 1'b0;
        repeat (gap) tick();
        exp_q.push_back(d);
        S_DATA = d;
        S_VALID = 1'b1;
        while (!S_READY && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got=no_ready want=ready");
        end
        tick();
        S_VALID = 1'b0;
    endtask

    // The stale FULL from the previous filter is dropped once the second word is in.
    task automatic load_filter(input int n, input logic [31:0] base, input bit rnd);
        beat_cnt = 0;
        for (int i = 0; i < n; i++) begin
            beat(base + 32'(i), rnd ? int'($urandom_range(0, 1)) : 0);
            if (i == 1) WS_FULL = 1'b0;
        end
        check("beat_count", 32'(beat_cnt), 32'(n));
        check("ready_drop", S_READY, 0);
    endtask

    task automatic finish_filter(input bit last);
        WS_FULL = 1'b1;
        tick();
        check("w_ready", W_READY, 1);
        W_RELEASE = 1'b1;
        tick();
        W_RELEASE = 1'b0;
        check("done_after_release", DONE, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        tick();
        tick();
        RESET = 1'b0;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_ready", S_READY, 0);
        check("rst_param_r", WS_PARAM_R, 0);
        check("rst_idx", FILTER_IDX, 0);

        // 3x3, one filter, back-to-back words
        start(3, 3, 1);
        check("t1_busy", BUSY, 1);
        c0 = cyc;
        load_filter(3, 32'h1100_0000, 0);
        check("t1_consecutive", 32'(cyc - c0), 3);
        S_VALID = 1'b1;
        S_DATA = 32'hDEAD_BEEF;
        WS_FULL = 1'b1;
        tick();
        check("t1_w_ready", W_READY, 1);
        tick();
        S_VALID = 1'b0;
        check("t1_hold", W_READY, 1);
        finish_filter(1);
        check("t1_busy_end", BUSY, 0);
        check("t1_wready_end", W_READY, 0);
        tick();
        check("t1_done_pulse", DONE, 0);

        // 5x5, two filters, random gaps, FULL lingering into each load
        start(5, 5, 2);
        check("t2_param_r", WS_PARAM_R, 5);
        check("t2_idx0", FILTER_IDX, 0);
        load_filter(7, 32'h2200_0000, 1);
        finish_filter(0);
        check("t2_idx1", FILTER_IDX, 1);
        check("t2_wready_low", W_READY, 0);
        check("t2_busy", BUSY, 1);
        load_filter(7, 32'h2300_0000, 1);
        finish_filter(1);

        // 4x4 with the store never reporting FULL
        start(4, 4, 1);
        load_filter(4, 32'h3300_0000, 0);
        repeat (14) tick();
        check("t3_no_err_yet", ERR, 0);
        check("t3_still_busy", BUSY, 1);
        tick();
        check("t3_err", ERR, 1);
        check("t3_idle", BUSY, 0);
        start(2, 2, 1);
        check("t3_err_cleared", ERR, 0);
        load_filter(2, 32'h3400_0000, 0);
        finish_filter(1);

        // invalid configurations
        start(6, 3, 1);
        check("t4_err_r", ERR, 1);
        check("t4_busy_r", BUSY, 0);
        check("t4_param_r", WS_PARAM_R, 2);
        start(3, 3, 0);
        check("t4_err_nf", ERR, 1);
        check("t4_busy_nf", BUSY, 0);
        check("t4_param_s", WS_PARAM_S, 2);

        // reset mid-load, then a clean 2x2 job
        WS_FULL = 1'b0;
        start(5, 5, 1);
        for (int i = 0; i < 3; i++) beat(32'h5500_0000 + 32'(i), 0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("t5_busy", BUSY, 0);
        check("t5_ready", S_READY, 0);
        check("t5_wr_en", WS_WR_EN, 0);
        check("t5_param_r", WS_PARAM_R, 0);
        check("t5_param_s", WS_PARAM_S, 0);
        check("t5_idx", FILTER_IDX, 0);
        check("t5_err", ERR, 0);
        start(2, 2, 1);
        load_filter(2, 32'h5600_0000, 0);
        finish_filter(1);

        // stray release/start during LOAD, then early FULL at word 3 of 7
        start(5, 5, 2);
        beat(32'h6600_0000, 0);
        CFG_R = 4'd1;
        CFG_S = 4'd1;
        CFG_NUM_FILTERS = 8'd9;
        CFG_START = 1'b1;
        W_RELEASE = 1'b1;
        tick();
        CFG_START = 1'b0;
        W_RELEASE = 1'b0;
        check("t6_idx", FILTER_IDX, 0);
        check("t6_param_r", WS_PARAM_R, 5);
        check("t6_ready", S_READY, 1);
        beat(32'h6600_0001, 0);
        WS_FULL = 1'b0;
        beat(32'h6600_0002, 0);
        check("t6_no_err", ERR, 0);
        WS_FULL = 1'b1;
        tick();
        check("t6_err", ERR, 1);
        check("t6_idle", BUSY, 0);
        check("t6_ready_off", S_READY, 0);
        WS_FULL = 1'b0;
        tick();
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
